// File: rtl/serial_adder_pkg.sv
// Shared constants and state encoding for the bit-serial adder.
package serial_arith_pkg;

    localparam int SA_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } sa_state_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder; the sub wire exists only with SERIAL_ADDER_SUB_EN.
interface serial_adder_if #(
    parameter int WIDTH = serial_arith_pkg::SA_DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_fa_cell.sv
// Single combinational full-adder cell used by the serial datapath.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder, LSB first, one bit per clock through a single full-adder cell.
// Optional subtract/borrow mode is built when SERIAL_ADDER_SUB_EN is defined.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_sub;

    logic             w_sub_in;
    logic             w_y;
    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_sum_next;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + ~cin; the final carry is the inverted borrow.
    assign w_sub_in = bus.sub;
    assign w_y      = r_b_sh[0] ^ r_sub;
`else
    assign w_sub_in = 1'b0;
    assign w_y      = r_b_sh[0];
`endif

    fa_cell u_fa (
        .x  (r_a_sh[0]),
        .y  (w_y),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    assign w_sum_next = {w_s, r_sum_sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_sub    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a_sh  <= bus.a;
                        r_b_sh  <= bus.b;
                        r_carry <= bus.cin ^ w_sub_in;
                        r_sub   <= w_sub_in;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_sum_sh <= w_sum_next;
                    r_carry  <= w_co;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_sum   <= w_sum_next;
                        r_cout  <= w_co ^ r_sub;
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign bus.done = (r_state == ST_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: vector table plus hand-written multi-cycle sequences.
module tb_serial_adder;
    localparam int W = 8;

    typedef struct {
        string      name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic       cin;
        logic       sub;
        logic [W-1:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] held_sum = '0;
    logic         held_cout = 1'b0;

    serial_adder_if #(.WIDTH(W)) bus ();
    serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = sub;
`else
        if (sub) $display("note: sub request ignored in add-only build");
`endif
    endtask

    // Starts one operation and checks busy, latency, held outputs, result and the DONE exit.
    task automatic run_op(input vec_t v);
        int   n;
        logic got;
        logic changed;
        @(negedge clk);
        drive(v.a, v.b, v.cin, v.sub);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({v.name, " busy@0"}, 32'(bus.busy), 32'd1);
        n = 0; got = 1'b0; changed = 1'b0;
        while (!got && n < W + 4) begin
            @(posedge clk); #1;
            n++;
            if (bus.done) got = 1'b1;
            else if (bus.sum !== held_sum || bus.cout !== held_cout) changed = 1'b1;
        end
        chk({v.name, " latency"}, got ? n : 32'hDEAD, W);
        chk({v.name, " held"}, 32'(changed), 32'd0);
        chk({v.name, " sum"}, 32'(bus.sum), 32'(v.exp_sum));
        chk({v.name, " cout"}, 32'(bus.cout), 32'(v.exp_cout));
        held_sum  = v.exp_sum;
        held_cout = v.exp_cout;
        @(posedge clk); #1;
        chk({v.name, " done fall"}, 32'(bus.done), 32'd0);
        chk({v.name, " busy fall"}, 32'(bus.busy), 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        int dones;
        vecs.push_back('{"inc",   8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0});
        vecs.push_back('{"add",   8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0});
        vecs.push_back('{"wrap",  8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1});
        vecs.push_back('{"carry", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{"cin",   8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0});
        vecs.push_back('{"full",  8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{"sub_neg", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b1});
        vecs.push_back('{"sub_pos", 8'h20, 8'h10, 1'b1, 1'b1, 8'h0F, 1'b0});
        vecs.push_back('{"sub_eq",  8'h55, 8'h55, 1'b0, 1'b1, 8'h00, 1'b0});
        vecs.push_back('{"sub_add", 8'h3C, 8'h5A, 1'b1, 1'b0, 8'h97, 1'b0});
`endif

        rst = 1'b1;
        bus.start = 1'b0;
        drive('0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst sum",  32'(bus.sum),  32'd0);
        chk("rst cout", 32'(bus.cout), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i]);

        // Start held high and operands changed during RUN: one done, then a second operation.
        @(negedge clk);
        drive(8'h10, 8'h20, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.a = 8'hFF;
        dones = 0;
        for (int c = 1; c <= W + 1; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                dones++;
                chk("hold latency", c, W);
                chk("hold sum", 32'(bus.sum), 32'h30);
            end
        end
        chk("hold one done", dones, 1);
        chk("hold idle", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("hold restart busy", 32'(bus.busy), 32'd1);
        for (int c = 1; c < W; c++) begin
            @(posedge clk); #1;
        end
        chk("hold sum kept", 32'(bus.sum), 32'h30);
        @(posedge clk); #1;
        chk("second done", 32'(bus.done), 32'd1);
        chk("second sum", 32'(bus.sum), 32'h1F);
        chk("second cout", 32'(bus.cout), 32'd1);
        @(posedge clk); #1;

        // Reset at edge 4 of an operation abandons it.
        @(negedge clk);
        drive(8'h77, 8'h11, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst done", 32'(bus.done), 32'd0);
        chk("midrst sum",  32'(bus.sum),  32'd0);
        chk("midrst cout", 32'(bus.cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < W + 2; c++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        chk("midrst no done", dones, 0);
        held_sum = '0;
        held_cout = 1'b0;
        run_op('{"after_rst", 8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0});

        // rst and start together: rst wins.
        @(negedge clk);
        drive(8'h01, 8'h02, 1'b0, 1'b0);
        bus.start = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst beats start", 32'(bus.busy), 32'd0);
        chk("rst beats start sum", 32'(bus.sum), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder for the arithmetic-cell track. It accepts two WIDTH-bit operands and a carry-in on a start strobe, then processes one bit per clock, LSB first, through a single full-adder cell with a registered carry. It reports the sum and carry-out with a one-cycle done pulse. It trades latency for area against the combinational adder and subtractor cells, and can optionally run in subtract mode, reporting a borrow.

## Interface
- WIDTH, default 8, operand and result width in bits, minimum 2.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  minuend or augend; captured on an accepted start.
- b  in  WIDTH  addend or subtrahend; captured on an accepted start.
- cin  in  1  carry-in, or borrow-in in subtract mode; captured on an accepted start.
- sub  in  1  subtract select; present only with SERIAL_ADDER_SUB_EN; captured on an accepted start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse when the result is valid.
- sum  out  WIDTH  result, held until the next accepted start.
- cout  out  1  carry-out, or borrow-out in subtract mode; held with sum.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - load shift registers a_sh←a and b_sh←b;
  - carry←cin (or ~cin in subtract mode);
  - clear the bit counter;
  - go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each cycle:
  - the full-adder cell takes a_sh[0], the effective b bit (b_sh[0], or ~b_sh[0] in subtract mode) and carry;
  - the cell's sum bit shifts into sum_sh at the MSB; a_sh, b_sh and sum_sh shift right by one;
  - carry←cell carry; the counter increments.
- RUN, counter=WIDTH-1:
  - the last bit is processed;
  - sum←final sum_sh, cout←final carry (inverted in subtract mode);
  - go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start is ignored in RUN and DONE. Inputs a, b, cin and sub may change freely after acceptance.
- Arithmetic:
  - add: {cout,sum} = a + b + cin;
  - subtract: sum = (a − b − cin) mod 2^WIDTH, cout = 1 iff a < b + cin (unsigned).
  - sum wraps modulo 2^WIDTH; the extra bit appears only on cout.
- Counter width is $clog2(WIDTH); the counter never wraps within one operation.

## Timing
- Reset values: sum=0, cout=0, busy=0, done=0; state=IDLE; carry, counter and shift registers all 0.
- Reset mid-operation (RUN or DONE) abandons the operation with no done pulse, and all outputs take their reset values on that edge.
- Let edge 0 be the edge that accepts start:
  - busy=1 from edge 0;
  - bits are processed at edges 1..WIDTH;
  - sum and cout update, and done rises, at edge WIDTH;
  - done falls and busy falls at edge WIDTH+1.
- Latency from start to done is WIDTH cycles. Throughput is one operation per WIDTH+2 cycles.
- sum and cout are unchanged between done pulses; they do not show intermediate bits.
- rst and start in the same cycle: rst wins.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - the sub port exists;
  - sub=1 selects subtract mode, with inverted b bits, carry initialised to ~cin, and cout reported as the inverted final carry (borrow);
  - sub=0 behaves as add.
- SERIAL_ADDER_SUB_EN undefined: no sub port; the block is add-only and none of the inversion logic exists.

## Structure
- Package serial_arith_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - the default-width constant;
  - the state encoding constants.
- One sub-module, fa_cell: a combinational full adder with inputs x, y, ci and outputs s, co. It is instantiated once and driven from the shift-register LSBs.
- Top level: FSM, bit counter, three shift registers, carry flop and output registers.

## Test plan
- Reset: assert rst for 2 cycles → sum=0, cout=0, busy=0, done=0; then start with a=8'h01, b=8'h01 → sum=8'h02 after 8 cycles.
- Add: a=8'h3C, b=8'h5A, cin=0, start at edge 0 → done high exactly at edge 8, sum=8'h96, cout=0, busy low at edge 9.
- Wrap and carry: a=8'hFF, b=8'h01, cin=1 → sum=8'h01, cout=1.
- Start held and inputs changed during RUN: a=8'h10, b=8'h20 accepted, then a=8'hFF with start held → sum=8'h30, exactly one done pulse; a second operation begins only after IDLE.
- Reset mid-run: rst at edge 4 of an operation → no done, outputs 0; a next start with a=8'h05, b=8'h03 → sum=8'h08.
- With SERIAL_ADDER_SUB_EN:
  - sub=1, a=8'h10, b=8'h20, cin=0 → sum=8'hF0, cout=1;
  - sub=1, a=8'h20, b=8'h10, cin=1 → sum=8'h0F, cout=0.
